// File: rtl/io_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// io_strobe_sequencer
//
// Clocked bus-cycle sequencer feeding a dual 2-to-4 chip-select decoder.
// Each accepted request runs SETUP -> STROBE -> HOLD. A_2D is stable before,
// during and after the low pulse on Enable_bar, so exactly one decoded select
// line pulses low for STROBE_CYC clocks, with no glitches.
//
// Parameters:
//   SETUP_CYC  - clocks A_2D is stable before Enable_bar falls (0 = no setup)
//   STROBE_CYC - clocks Enable_bar is held low (1 .. 2**CNT_W-1)
//   HOLD_CYC   - clocks A_2D is held after Enable_bar rises (0 = no hold)
//   CNT_W      - width of the phase counter
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   req        - request valid; transfer on any edge with req & req_ready
//   req_addr   - select code for this access
//   req_ready  - a request can be accepted this cycle
//   busy       - SETUP, STROBE or HOLD in progress
//   done       - one-clock pulse in the first cycle after an access
//   Enable_bar - registered active-low decoder enable
//   A_2D       - registered decoder select lines
//
// Optional feature (macro IO_STROBE_PENDING_EN):
//   Adds a one-entry pending buffer so a request accepted during an access is
//   launched at its end with no IDLE gap. Without the macro, requests are only
//   accepted in IDLE.
// -----------------------------------------------------------------------------
module io_strobe_sequencer #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1,
    parameter int CNT_W      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [1:0] req_addr,
    output logic       req_ready,
    output logic       busy,
    output logic       done,
    output logic       Enable_bar,
    output logic [1:0] A_2D
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_HOLD   = 2'd3;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    // First phase of an access: SETUP, or STROBE directly when there is no setup.
    localparam logic [1:0]       FIRST_STATE  = (SETUP_CYC > 0) ? ST_SETUP : ST_STROBE;
    localparam logic [CNT_W-1:0] FIRST_CNT    = (SETUP_CYC > 0) ? SETUP_LD : STROBE_LD;
    localparam logic             FIRST_EN_BAR = (SETUP_CYC > 0) ? 1'b1 : 1'b0;

    logic [1:0]       state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [1:0]       a2d_reg,    a2d_next;
    logic             en_bar_reg, en_bar_next;
    logic             done_reg,   done_next;

    logic       accept;
    logic       phase_last;
    logic       end_access;
    logic       launch_go;
    logic [1:0] launch_addr;

`ifdef IO_STROBE_PENDING_EN
    logic       pend_valid_reg, pend_valid_next;
    logic [1:0] pend_addr_reg,  pend_addr_next;

    // While busy, one more request may be parked in the buffer.
    assign req_ready = (state_reg == ST_IDLE) || !pend_valid_reg;
`else
    assign req_ready = (state_reg == ST_IDLE);
`endif

    assign accept     = req && req_ready;
    assign phase_last = (cnt_reg == CNT_ONE);
    assign busy       = (state_reg != ST_IDLE);

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        a2d_next    = a2d_reg;
        en_bar_next = en_bar_reg;
        done_next   = 1'b0;
        end_access  = 1'b0;
        launch_go   = 1'b0;
        launch_addr = req_addr;
`ifdef IO_STROBE_PENDING_EN
        pend_valid_next = pend_valid_reg;
        pend_addr_next  = pend_addr_reg;
`endif

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    launch_go = 1'b1;
                end
            end
            ST_SETUP: begin
                if (phase_last) begin
                    state_next  = ST_STROBE;
                    cnt_next    = STROBE_LD;
                    en_bar_next = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_STROBE: begin
                if (phase_last) begin
                    if (HOLD_CYC > 0) begin
                        state_next  = ST_HOLD;
                        cnt_next    = HOLD_LD;
                        en_bar_next = 1'b1;
                    end else begin
                        end_access = 1'b1;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            ST_HOLD: begin
                if (phase_last) begin
                    end_access = 1'b1;
                end else begin
                    cnt_next = cnt_reg - CNT_ONE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (end_access) begin
            done_next   = 1'b1;
            state_next  = ST_IDLE;
            cnt_next    = '0;
            en_bar_next = 1'b1;
`ifdef IO_STROBE_PENDING_EN
            if (pend_valid_reg) begin
                launch_go       = 1'b1;
                launch_addr     = pend_addr_reg;
                pend_valid_next = 1'b0;
            end else if (accept) begin
                // A request arriving on the final edge goes straight out
                // rather than through the buffer.
                launch_go = 1'b1;
            end
`endif
        end

`ifdef IO_STROBE_PENDING_EN
        // Written after the clear so that a new entry takes priority.
        if (accept && busy && !end_access) begin
            pend_valid_next = 1'b1;
            pend_addr_next  = req_addr;
        end
`endif

        if (launch_go) begin
            state_next  = FIRST_STATE;
            cnt_next    = FIRST_CNT;
            en_bar_next = FIRST_EN_BAR;
            a2d_next    = launch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            cnt_reg    <= '0;
            a2d_reg    <= 2'b00;
            en_bar_reg <= 1'b1;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            a2d_reg    <= a2d_next;
            en_bar_reg <= en_bar_next;
            done_reg   <= done_next;
        end
    end

`ifdef IO_STROBE_PENDING_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_reg <= 1'b0;
            pend_addr_reg  <= 2'b00;
        end else begin
            pend_valid_reg <= pend_valid_next;
            pend_addr_reg  <= pend_addr_next;
        end
    end
`endif

    assign Enable_bar = en_bar_reg;
    assign A_2D       = a2d_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_io_strobe_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for io_strobe_sequencer. Three instances with different timing:
//   0: SETUP=1 STROBE=2  HOLD=1 (defaults)
//   1: SETUP=0 STROBE=1  HOLD=0
//   2: SETUP=1 STROBE=15 HOLD=1 (counter boundary)
// Stimulus pushes the expected access (address, strobe length, done cycle)
// into a per-instance queue; a monitor pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_io_strobe_sequencer;

    localparam int N_DUT = 3;
`ifdef IO_STROBE_PENDING_EN
    localparam logic PEND = 1'b1;
`else
    localparam logic PEND = 1'b0;
`endif

    typedef struct {
        logic [1:0] addr;
        int         run;
        int         done_cyc;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       req       [N_DUT];
    logic [1:0] req_addr  [N_DUT];
    logic       req_ready [N_DUT];
    logic       busy      [N_DUT];
    logic       done      [N_DUT];
    logic       en_bar    [N_DUT];
    logic [1:0] a2d       [N_DUT];

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t exp_q [N_DUT][$];

    // monitor state
    int         cur_run   [N_DUT];
    int         last_run  [N_DUT];
    logic [1:0] run_addr  [N_DUT];
    logic [1:0] last_addr [N_DUT];
    logic       prev_en   [N_DUT];
    logic [1:0] prev_a2d  [N_DUT];

    genvar gi;
    generate
        for (gi = 0; gi < N_DUT; gi++) begin : gen_dut
            io_strobe_sequencer #(
                .SETUP_CYC (gi == 1 ? 0 : 1),
                .STROBE_CYC(gi == 0 ? 2 : (gi == 1 ? 1 : 15)),
                .HOLD_CYC  (gi == 1 ? 0 : 1),
                .CNT_W     (4)
            ) u_dut (
                .clk       (clk),
                .reset     (reset),
                .req       (req[gi]),
                .req_addr  (req_addr[gi]),
                .req_ready (req_ready[gi]),
                .busy      (busy[gi]),
                .done      (done[gi]),
                .Enable_bar(en_bar[gi]),
                .A_2D      (a2d[gi])
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] y_2d(input logic [1:0] a, input logic enb);
        logic [3:0] one;
        one = 4'b0001;
        return enb ? 4'b1111 : ~(one << a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_acc(input int i, input logic [1:0] a, input int run, input int dc);
        exp_t e;
        e.addr     = a;
        e.run      = run;
        e.done_cyc = dc;
        exp_q[i].push_back(e);
        $display("expect dut%0d addr=%0d strobe=%0d done_cycle=%0d", i, a, run, dc);
    endtask

    // Called at a negedge. Holds req until accepted; acc is the cycle count
    // right after the accepting edge. Returns at the negedge after that edge.
    task automatic send(input int i, input logic [1:0] a, output int acc);
        int n;
        n = 0;
        req[i]      = 1'b1;
        req_addr[i] = a;
        while (req_ready[i] !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout dut%0d: req_ready=%0b required 1", i, req_ready[i]);
        end
        acc = cyc + 1;
        @(negedge clk);
        req[i] = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < N_DUT; i++) begin
            if (reset) begin
                cur_run[i] = 0;
            end else begin
                if (en_bar[i] === 1'b0) begin
                    if (cur_run[i] == 0) begin
                        run_addr[i] = a2d[i];
                    end else begin
                        checks++;
                        if (a2d[i] !== prev_a2d[i]) begin
                            failures++;
                            $display("FAIL a2d_stable_in_strobe dut%0d: got %0d required %0d", i, a2d[i], prev_a2d[i]);
                        end
                    end
                    cur_run[i]++;
                end else if (cur_run[i] > 0) begin
                    last_run[i]  = cur_run[i];
                    last_addr[i] = run_addr[i];
                    cur_run[i]   = 0;
                end
                if (i != 1 && en_bar[i] !== prev_en[i]) begin
                    checks++;
                    if (a2d[i] !== prev_a2d[i]) begin
                        failures++;
                        $display("FAIL a2d_en_same_edge dut%0d: A_2D %0d->%0d with Enable_bar change", i, prev_a2d[i], a2d[i]);
                    end
                end
                if (done[i] === 1'b1) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_done dut%0d: done=1 with no access outstanding (cycle %0d)", i, cyc);
                    end else begin
                        exp_t e;
                        e = exp_q[i].pop_front();
                        $display("done dut%0d cycle=%0d addr=%0d strobe=%0d", i, cyc, last_addr[i], last_run[i]);
                        chk($sformatf("sb_addr dut%0d", i), 32'(last_addr[i]), 32'(e.addr));
                        chk($sformatf("sb_strobe_len dut%0d", i), last_run[i], e.run);
                        chk($sformatf("sb_done_cycle dut%0d", i), cyc, e.done_cyc);
                    end
                end
            end
            prev_en[i]  = en_bar[i];
            prev_a2d[i] = a2d[i];
        end
    end

    initial begin
        int a, a1, a2, a3;
        for (int i = 0; i < N_DUT; i++) begin
            req[i]       = 1'b0;
            req_addr[i]  = 2'b00;
            cur_run[i]   = 0;
            last_run[i]  = 0;
            run_addr[i]  = 2'b00;
            last_addr[i] = 2'b00;
            prev_en[i]   = 1'b1;
            prev_a2d[i]  = 2'b00;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("rst_enable_bar dut%0d", i), 32'(en_bar[i]), 1);
            chk($sformatf("rst_a2d dut%0d", i), 32'(a2d[i]), 0);
            chk($sformatf("rst_done dut%0d", i), 32'(done[i]), 0);
            chk($sformatf("rst_busy dut%0d", i), 32'(busy[i]), 0);
            chk($sformatf("rst_ready dut%0d", i), 32'(req_ready[i]), 1);
        end
        reset = 1'b0;
        @(negedge clk);

        // Defaults: addr 2, cycle-by-cycle
        send(0, 2'd2, a);
        expect_acc(0, 2'd2, 2, a + 4);
        chk("t1_setup_a2d", 32'(a2d[0]), 2);
        chk("t1_setup_enb", 32'(en_bar[0]), 1);
        chk("t1_setup_busy", 32'(busy[0]), 1);
        chk("t1_setup_ready", 32'(req_ready[0]), 32'(PEND));
        @(negedge clk);
        chk("t1_strobe1_enb", 32'(en_bar[0]), 0);
        chk("t1_strobe1_y", 32'(y_2d(a2d[0], en_bar[0])), 32'h0000000B);
        @(negedge clk);
        chk("t1_strobe2_enb", 32'(en_bar[0]), 0);
        @(negedge clk);
        chk("t1_hold_enb", 32'(en_bar[0]), 1);
        chk("t1_hold_busy", 32'(busy[0]), 1);
        chk("t1_hold_y", 32'(y_2d(a2d[0], en_bar[0])), 32'h0000000F);
        @(negedge clk);
        chk("t1_done", 32'(done[0]), 1);
        chk("t1_done_busy", 32'(busy[0]), 0);
        chk("t1_idle_a2d_kept", 32'(a2d[0]), 2);
        @(negedge clk);
        chk("t1_done_pulse_end", 32'(done[0]), 0);

        // No setup/hold, one-cycle strobe, addr 3
        send(1, 2'd3, a);
        expect_acc(1, 2'd3, 1, a + 1);
        chk("t2_strobe_enb", 32'(en_bar[1]), 0);
        chk("t2_strobe_a2d", 32'(a2d[1]), 3);
        @(negedge clk);
        chk("t2_done", 32'(done[1]), 1);
        chk("t2_after_enb", 32'(en_bar[1]), 1);
        repeat (3) @(negedge clk);

        // Reset during the second strobe cycle aborts with no done
        send(0, 2'd2, a);
        @(negedge clk);
        chk("t3_strobe1_enb", 32'(en_bar[0]), 0);
        @(negedge clk);
        chk("t3_strobe2_enb", 32'(en_bar[0]), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t3_abort_enb", 32'(en_bar[0]), 1);
        chk("t3_abort_a2d", 32'(a2d[0]), 0);
        chk("t3_abort_busy", 32'(busy[0]), 0);
        chk("t3_abort_done", 32'(done[0]), 0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("t3_no_done", 32'(done[0]), 0);
        end
        send(0, 2'd1, a);
        expect_acc(0, 2'd1, 2, a + 4);
        repeat (8) @(negedge clk);

`ifdef IO_STROBE_PENDING_EN
        // Pending: second req during STROBE, third held off by a full buffer
        send(0, 2'd1, a1);
        expect_acc(0, 2'd1, 2, a1 + 4);
        @(negedge clk);
        chk("t4p_in_strobe", 32'(en_bar[0]), 0);
        send(0, 2'd0, a2);
        chk("t4p_second_accept", a2, a1 + 2);
        expect_acc(0, 2'd0, 2, a1 + 8);
        chk("t4p_ready_full", 32'(req_ready[0]), 0);
        send(0, 2'd3, a3);
        chk("t4p_third_accept", a3, a1 + 5);
        expect_acc(0, 2'd3, 2, a1 + 12);
        repeat (14) @(negedge clk);
`else
        // Held req while busy is ignored until IDLE
        send(0, 2'd1, a1);
        expect_acc(0, 2'd1, 2, a1 + 4);
        chk("t4_busy_ready", 32'(req_ready[0]), 0);
        send(0, 2'd3, a2);
        chk("t4_second_accept", a2, a1 + 5);
        expect_acc(0, 2'd3, 2, a2 + 4);
        repeat (8) @(negedge clk);
`endif

        // Counter boundary: 15-cycle strobe
        send(2, 2'd0, a);
        expect_acc(2, 2'd0, 15, a + 17);
        repeat (4) @(negedge clk);
        chk("t5_mid_strobe_enb", 32'(en_bar[2]), 0);
        repeat (20) @(negedge clk);
        send(2, 2'd1, a);
        expect_acc(2, 2'd1, 15, a + 17);
        repeat (25) @(negedge clk);

        for (int i = 0; i < N_DUT; i++) begin
            chk($sformatf("sb_drained dut%0d", i), exp_q[i].size(), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
